// File: rtl/reg_file_if.sv
// Register-file bus: one write port, two registered read ports and the
// pending-write scoreboard lock/busy signals.
interface reg_file_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr1;
  logic [WIDTH-1:0] rdata1;
  logic [AW-1:0]    raddr2;
  logic [WIDTH-1:0] rdata2;
  logic             lock;
  logic [AW-1:0]    lock_addr;
  logic             busy1;
  logic             busy2;

  // Datapath side: decode/writeback drive addresses, data and locks.
  modport master (
    output we, waddr, wdata, raddr1, raddr2, lock, lock_addr,
    input  rdata1, rdata2, busy1, busy2
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2, lock, lock_addr,
    output rdata1, rdata2, busy1, busy2
  );
endinterface

// File: rtl/reg_file.sv
// Two-read, one-write MIPS register file with synchronous write-first reads,
// hardwired r0 and a per-register pending-write scoreboard.
module reg_file #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic      clk,
  input  logic      rst,
  reg_file_if.slave bus
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_next;

  logic             write_hit;
  logic             lock_hit;
  logic [WIDTH-1:0] rdata1_next;
  logic [WIDTH-1:0] rdata2_next;
  logic             busy1_next;
  logic             busy2_next;

  // r0 is never written or locked, so both enables exclude address 0.
  assign write_hit = bus.we   && (bus.waddr     != '0);
  assign lock_hit  = bus.lock && (bus.lock_addr != '0);

  // Post-edge scoreboard: a write clears its bit, then a lock may set it,
  // so lock+write to the same register leaves it pending.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    pending_next = pending;
    if (write_hit) pending_next[bus.waddr]     = 1'b0;
    if (lock_hit)  pending_next[bus.lock_addr] = 1'b1;
  end

  // Read port 1: r0 reads zero, a same-edge write to the address forwards.
  always_comb begin
    rdata1_next = regs[bus.raddr1];
    if (bus.raddr1 == '0) begin
      rdata1_next = '0;
    end else if (write_hit && (bus.waddr == bus.raddr1)) begin
      rdata1_next = bus.wdata;
    end
  end

  always_comb begin
    rdata2_next = regs[bus.raddr2];
    if (bus.raddr2 == '0) begin
      rdata2_next = '0;
    end else if (write_hit && (bus.waddr == bus.raddr2)) begin
      rdata2_next = bus.wdata;
    end
  end

  // Busy reports the post-edge pending bit; pending[0] is never set.
  assign busy1_next = pending_next[bus.raddr1];
  assign busy2_next = pending_next[bus.raddr2];

  // Storage and scoreboard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the register array is reset here on purpose: software and the
      // test plan rely on every register reading zero after reset, which
      // costs a reset flop per bit instead of a plain RAM.
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      pending <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (write_hit) regs[bus.waddr] <= bus.wdata;
      pending <= pending_next;
    end
  end

  // Registered read outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rdata1 <= '0;
      bus.rdata2 <= '0;
      bus.busy1  <= 1'b0;
      bus.busy2  <= 1'b0;
    end else begin
      bus.rdata1 <= rdata1_next;
      bus.rdata2 <= rdata2_next;
      bus.busy1  <= busy1_next;
      bus.busy2  <= busy2_next;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table plus hand-written
// reset, fill and mid-cycle asynchronous reset sequences.
module tb_reg_file;
  localparam int WIDTH = 32;
  localparam int AW    = 5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  reg_file_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  reg_file #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr1;
    logic [AW-1:0]    raddr2;
    logic             lock;
    logic [AW-1:0]    lock_addr;
    logic [WIDTH-1:0] exp_rdata1;
    logic             exp_busy1;
    logic [WIDTH-1:0] exp_rdata2;
    logic             exp_busy2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [AW-1:0] waddr,
                              input logic [WIDTH-1:0] wdata,
                              input logic [AW-1:0] raddr1, input logic [AW-1:0] raddr2,
                              input logic lock, input logic [AW-1:0] lock_addr,
                              input logic [WIDTH-1:0] e1, input logic b1,
                              input logic [WIDTH-1:0] e2, input logic b2);
    vec_t v;
    v.we = we; v.waddr = waddr; v.wdata = wdata;
    v.raddr1 = raddr1; v.raddr2 = raddr2;
    v.lock = lock; v.lock_addr = lock_addr;
    v.exp_rdata1 = e1; v.exp_busy1 = b1;
    v.exp_rdata2 = e2; v.exp_busy2 = b2;
    return v;
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [WIDTH-1:0] e1,
                               input logic b1, input logic [WIDTH-1:0] e2,
                               input logic b2);
    check({tag, " rdata1"}, bus.rdata1, e1);
    check({tag, " busy1"},  {{(WIDTH-1){1'b0}}, bus.busy1}, {{(WIDTH-1){1'b0}}, b1});
    check({tag, " rdata2"}, bus.rdata2, e2);
    check({tag, " busy2"},  {{(WIDTH-1){1'b0}}, bus.busy2}, {{(WIDTH-1){1'b0}}, b2});
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] waddr,
                       input logic [WIDTH-1:0] wdata,
                       input logic [AW-1:0] raddr1, input logic [AW-1:0] raddr2,
                       input logic lock, input logic [AW-1:0] lock_addr);
    bus.we = we; bus.waddr = waddr; bus.wdata = wdata;
    bus.raddr1 = raddr1; bus.raddr2 = raddr2;
    bus.lock = lock; bus.lock_addr = lock_addr;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < (1 << AW); i++) begin
      drive(1'b0, '0, '0, AW'(i), AW'((1 << AW) - 1 - i), 1'b0, '0);
      step();
      check_outputs($sformatf("%s r%0d/r%0d", tag, i, (1 << AW) - 1 - i),
                    '0, 1'b0, '0, 1'b0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // we waddr wdata raddr1 raddr2 lock lock_addr | rdata1 busy1 rdata2 busy2
    vecs.push_back(mk(1, 5,  32'hDEADBEEF, 0,  0,  0, 0,  32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(0, 0,  32'h0,        5,  5,  0, 0,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 0,  32'h12345678, 0,  0,  1, 0,  32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(0, 0,  32'h0,        0,  0,  0, 0,  32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(1, 7,  32'h11,       1,  2,  0, 0,  32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(1, 7,  32'h22,       7,  7,  0, 0,  32'h22,       0, 32'h22,       0));
    vecs.push_back(mk(0, 0,  32'h0,        7,  5,  0, 0,  32'h22,       0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 0,  32'h0,        9,  5,  1, 9,  32'h0,        1, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 0,  32'h0,        9,  9,  0, 0,  32'h0,        1, 32'h0,        1));
    vecs.push_back(mk(1, 9,  32'hAB,       9,  9,  0, 0,  32'hAB,       0, 32'hAB,       0));
    vecs.push_back(mk(0, 0,  32'h0,        9,  9,  0, 0,  32'hAB,       0, 32'hAB,       0));
    vecs.push_back(mk(1, 9,  32'hCD,       9,  9,  1, 9,  32'hCD,       1, 32'hCD,       1));
    vecs.push_back(mk(0, 0,  32'h0,        9,  9,  0, 0,  32'hCD,       1, 32'hCD,       1));
    vecs.push_back(mk(1, 11, 32'h55,       10, 11, 1, 10, 32'h0,        1, 32'h55,       0));
    vecs.push_back(mk(0, 0,  32'h0,        11, 10, 0, 0,  32'h55,       0, 32'h0,        1));
    vecs.push_back(mk(1, 10, 32'h66,       10, 10, 0, 0,  32'h66,       0, 32'h66,       0));
    vecs.push_back(mk(1, 31, 32'hFFFFFFFF, 31, 10, 0, 0,  32'hFFFFFFFF, 0, 32'h66,       0));
    vecs.push_back(mk(0, 0,  32'h0,        31, 0,  0, 0,  32'hFFFFFFFF, 0, 32'h0,        0));

    // Reset held low: outputs must be zero before any clock edge.
    rst = 1'b0;
    drive(1'b0, '0, '0, '0, '0, 1'b0, '0);
    #1;
    check_outputs("reset", '0, 1'b0, '0, 1'b0);
    step();
    step();
    rst = 1'b1;
    read_all("post-reset");

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr1,
            vecs[i].raddr2, vecs[i].lock, vecs[i].lock_addr);
      step();
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_rdata1, vecs[i].exp_busy1,
                    vecs[i].exp_rdata2, vecs[i].exp_busy2);
    end

    // Fill r1..r31 with 0x100+n, then lock r3 while reading r3 and r31.
    for (int n = 1; n < (1 << AW); n++) begin
      drive(1'b1, AW'(n), 32'h100 + WIDTH'(n), '0, '0, 1'b0, '0);
      step();
    end
    drive(1'b0, '0, '0, 5'd3, 5'd31, 1'b1, 5'd3);
    step();
    check_outputs("fill lock r3", 32'h103, 1'b1, 32'h11F, 1'b0);

    // Keep a write in flight while reset pulses between clock edges.
    drive(1'b1, 5'd4, 32'hBAD, 5'd3, 5'd31, 1'b0, '0);
    #2 rst = 1'b0;
    #1;
    check_outputs("async reset", '0, 1'b0, '0, 1'b0);
    #1 rst = 1'b1;
    read_all("after async reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Two-read, one-write general-purpose register file for the MIPS datapath. Decode reads from it and writeback writes to it. It also keeps a per-register pending-write scoreboard so that decode can detect operands still in flight from multi-cycle loads. Reads are synchronous, with write-first forwarding. Register 0 is hardwired to zero.

## Interface
- WIDTH, 32, data width of each register
- AW, 5, address width; the file holds 2^AW registers

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- raddr1  in  AW  read port 1 address
- rdata1  out  WIDTH  read port 1 data, registered
- raddr2  in  AW  read port 2 address
- rdata2  out  WIDTH  read port 2 data, registered
- lock  in  1  mark register lock_addr as pending-write
- lock_addr  in  AW  register to mark as pending
- busy1  out  1  pending bit of raddr1, registered alongside rdata1
- busy2  out  1  pending bit of raddr2, registered alongside rdata2

## Operation
- Storage holds 2^AW entries of WIDTH bits each, plus a 2^AW-bit pending vector.
- While rst=0, regardless of clk:
  - all entries clear to 0
  - the pending vector clears to 0
  - rdata1, rdata2, busy1 and busy2 all clear to 0
- Write:
  - on a clock edge with we=1 and waddr≠0, entry[waddr] takes wdata
  - the same edge clears pending[waddr]
- Register 0:
  - writes to address 0 are ignored
  - pending[0] is never set
  - reads of address 0 always return 0 with busy=0
- Lock:
  - on a clock edge with lock=1 and lock_addr≠0, pending[lock_addr] is set
- Lock and write to the same address on the same edge: the write lands and clears the bit first, then the lock sets it. Net result: data updated, pending=1.
- Lock and write to different addresses on the same edge: both take effect independently.
- Read, port n (n = 1, 2), on every clock edge:
  - rdatan takes entry[raddrn] as held before the edge
  - busyn takes pending[raddrn] as held before the edge
- Write-first forwarding applies when we=1, waddr=raddrn and waddr≠0:
  - rdatan takes wdata instead of the stored entry
  - busyn takes the post-edge pending value, i.e. 1 if a lock hits the same address that edge, else 0
- If a lock hits raddrn that edge without a write to it, busyn takes 1 (the post-edge value).
- Both read ports are independent; identical addresses on both ports are legal and return identical results.
- The block raises no errors; all address values are legal.

## Timing
- Read latency is 1 cycle: an address presented before edge N gives data valid after edge N.
- Write-to-read latency is 0 extra cycles with forwarding. Data written at edge N is visible on rdata at edge N when addresses match, and from the array from edge N+1 on.
- Lock-to-busy latency is 1 edge. A lock at edge N is visible as busy at edge N when raddr matches.
- Reset deassertion is synchronous-safe: the first edge at which rst=1 performs normal operation.
- Asserting reset mid-operation discards any in-flight write and clears all state immediately, without waiting for clk.

## Test plan
- Reset: hold rst=0, then release. Required: rdata1=rdata2=0, busy1=busy2=0, and reads of all 32 addresses return 0.
- Basic write/read: write 0xDEADBEEF to r5; one cycle later set raddr1=5 and raddr2=5. Required: both ports show 0xDEADBEEF one cycle later, busy=0.
- Zero register: write 0x12345678 to r0 with lock_addr=0, lock=1; read r0. Required: rdata=0, busy=0.
- Forwarding: r7 holds 0x11. On the same edge, write 0x22 to r7 with raddr1=7. Required: rdata1=0x22 after that edge, not 0x11.
- Scoreboard:
  - lock r9, then read r9. Required: busy=1.
  - write 0xAB to r9 while raddr2=9. Required: rdata2=0xAB, busy2=0.
  - lock and write r9 on the same edge. Required: rdata=new data, busy=1.
- Async reset mid-operation: fill r1–r31 with 0x100+n and lock r3, then pulse rst=0 between clock edges. Required: outputs go to 0 immediately, and all entries read 0 with busy=0 afterwards.
